// File: rtl/trigger_delay_pkg.sv
// Shared types and default widths for the trigger delay unit.
package trigger_delay_pkg;

    localparam int DELAY_W_DEF = 32;
    localparam int WIDTH_W_DEF = 16;
    localparam int EDGE_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_PULSE = 2'd3
    } state_t;

endpackage

// File: rtl/tdu_down_counter.sv
// Loadable down-counter that saturates at zero and flags the zero count.
module tdu_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/trigger_delay_fsm.sv
// Single-shot delayed trigger: arm, wait for the qualifying edge, delay, then pulse.
// Optional macro TRIG_EDGE_COUNT_EN makes the Nth edge in ARMED the qualifying one.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for arm; config not latched
// ARMED    | config latched, waiting for the qualifying edge
// DELAY    | delay counter running toward zero
// PULSE    | trigger_out high, pulse counter running
module trigger_delay_fsm
    import trigger_delay_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int WIDTH_W = WIDTH_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  edge_pulse,
    input  logic                  arm,
    input  logic                  disarm,
    input  logic [DELAY_W-1:0]    delay_cycles,
    input  logic [WIDTH_W-1:0]    pulse_width,
`ifdef TRIG_EDGE_COUNT_EN
    input  logic [EDGE_CNT_W-1:0] edge_count_target,
`endif
    output logic                  trigger_out,
    output logic                  armed,
    output logic                  busy,
    output logic                  done
);

    state_t               r_state;
    state_t               w_next;
    logic [DELAY_W-1:0]   r_delay;
    logic [WIDTH_W-1:0]   r_width;
    logic                 r_done;
    logic                 w_arm_ok;
    logic                 w_qualify;
    logic                 w_done_next;
    logic                 w_dly_zero;
    logic                 w_pls_zero;
    logic                 w_dly_load;
    logic                 w_pls_load;
    logic [DELAY_W-1:0]   w_dly_init;
    logic [WIDTH_W-1:0]   w_pls_init;

    assign w_arm_ok = (r_state == ST_IDLE) && arm && !disarm;

`ifdef TRIG_EDGE_COUNT_EN
    logic [EDGE_CNT_W-1:0] r_target;
    logic [EDGE_CNT_W-1:0] r_edge_cnt;
    logic [EDGE_CNT_W-1:0] w_target_m1;

    assign w_target_m1 = (r_target == '0) ? '0 : r_target - EDGE_CNT_W'(1);
    assign w_qualify   = edge_pulse && (r_edge_cnt == w_target_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target   <= '0;
            r_edge_cnt <= '0;
        end else begin
            if (w_arm_ok) begin
                r_target <= edge_count_target;
            end
            if (disarm || w_arm_ok) begin
                r_edge_cnt <= '0;
            end else if ((r_state == ST_ARMED) && edge_pulse && !w_qualify) begin
                r_edge_cnt <= r_edge_cnt + EDGE_CNT_W'(1);
            end
        end
    end
`else
    assign w_qualify = edge_pulse;
`endif

    always_comb begin
        w_next = r_state;
        if (disarm) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (arm)        w_next = ST_ARMED;
                // A zero delay skips DELAY so the pulse starts the cycle after the edge.
                ST_ARMED: if (w_qualify)  w_next = (r_delay == '0) ? ST_PULSE : ST_DELAY;
                ST_DELAY: if (w_dly_zero) w_next = ST_PULSE;
                ST_PULSE: if (w_pls_zero) w_next = ST_IDLE;
                default:                  w_next = ST_IDLE;
            endcase
        end
    end

    assign w_done_next = (r_state == ST_PULSE) && w_pls_zero && !disarm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_delay <= '0;
            r_width <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_next;
            if (w_arm_ok) begin
                r_delay <= delay_cycles;
                r_width <= pulse_width;
            end
        end
    end

    // Counters hold value-1 so the zero flag marks the last cycle of each phase.
    assign w_dly_init = r_delay - DELAY_W'(1);
    assign w_pls_init = (r_width == '0) ? '0 : r_width - WIDTH_W'(1);
    assign w_dly_load = (r_state == ST_ARMED) && (w_next == ST_DELAY);
    assign w_pls_load = (r_state != ST_PULSE) && (w_next == ST_PULSE);

    tdu_down_counter #(.W(DELAY_W)) u_dly_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_dly_load),
        .i_load_val (w_dly_init),
        .i_dec      (r_state == ST_DELAY),
        .o_zero     (w_dly_zero)
    );

    tdu_down_counter #(.W(WIDTH_W)) u_pls_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pls_load),
        .i_load_val (w_pls_init),
        .i_dec      (r_state == ST_PULSE),
        .o_zero     (w_pls_zero)
    );

    assign trigger_out = (r_state == ST_PULSE);
    assign armed       = (r_state == ST_ARMED);
    assign busy        = (r_state == ST_DELAY) || (r_state == ST_PULSE);
    assign done        = r_done;

endmodule

// File: tb/tb_trigger_delay_fsm.sv
// Bench for trigger_delay_fsm: timestamp-based reference model plus directed latency checks.
module tb_trigger_delay_fsm;

    localparam int DW = 6;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst, edge_pulse, arm, disarm;
    logic [DW-1:0] delay_cycles;
    logic [WW-1:0] pulse_width;
`ifdef TRIG_EDGE_COUNT_EN
    logic [15:0]   edge_count_target;
`endif
    logic          trigger_out, armed, busy, done;

    always #5 clk = ~clk;

    trigger_delay_fsm #(.DELAY_W(DW), .WIDTH_W(WW)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .edge_pulse        (edge_pulse),
        .arm               (arm),
        .disarm            (disarm),
        .delay_cycles      (delay_cycles),
        .pulse_width       (pulse_width),
`ifdef TRIG_EDGE_COUNT_EN
        .edge_count_target (edge_count_target),
`endif
        .trigger_out       (trigger_out),
        .armed             (armed),
        .busy              (busy),
        .done              (done)
    );

    int     n_cmp = 0;
    int     n_mis = 0;
    longint cyc   = 0;

    // Reference model: an armed flag plus the timestamps of the fired sequence.
    bit     m_armed = 0;
    bit     m_seq   = 0;
    longint m_d = 0, m_w = 1, m_n = 1, m_cnt = 0;
    longint m_edge_t = 0, m_start = 0, m_end = 0;

    longint rise_cyc = -1, done_cyc = -1;
    int     hi_cnt = 0, done_cnt = 0;
    logic   prev_trig = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit a, input bit d, input bit e,
                        input logic [DW-1:0] dl, input logic [WW-1:0] wd, input logic [15:0] tg);
        longint t;
        bit     idle_now;
        bit     e_trig, e_busy, e_done;
        rst          = r;
        arm          = a;
        disarm       = d;
        edge_pulse   = e;
        delay_cycles = dl;
        pulse_width  = wd;
`ifdef TRIG_EDGE_COUNT_EN
        edge_count_target = tg;
`endif
        @(posedge clk);
        t        = cyc;
        idle_now = !m_armed && !(m_seq && t > m_edge_t && t <= m_end);
        if (r || d) begin
            m_armed = 0;
            m_seq   = 0;
            m_cnt   = 0;
        end else if (idle_now && a) begin
            m_armed = 1;
            m_seq   = 0;
            m_cnt   = 0;
            m_d     = longint'(dl);
            m_w     = (wd == 0) ? 1 : longint'(wd);
`ifdef TRIG_EDGE_COUNT_EN
            m_n     = (tg == 0) ? 1 : longint'(tg);
`else
            m_n     = (tg == 16'hFFFF) ? 1 : 1;
`endif
        end else if (m_armed && e) begin
            m_cnt++;
            if (m_cnt >= m_n) begin
                m_armed  = 0;
                m_seq    = 1;
                m_edge_t = t;
                m_start  = t + 1 + m_d;
                m_end    = m_start + m_w - 1;
            end
        end
        cyc = t + 1;
        @(negedge clk);
        e_trig = m_seq && cyc >= m_start && cyc <= m_end;
        e_busy = m_seq && cyc > m_edge_t && cyc <= m_end;
        e_done = m_seq && cyc == m_end + 1;
        chk("armed",       64'(armed),       64'(m_armed));
        chk("busy",        64'(busy),        64'(e_busy));
        chk("trigger_out", 64'(trigger_out), 64'(e_trig));
        chk("done",        64'(done),        64'(e_done));
        if (trigger_out === 1'b1 && prev_trig !== 1'b1) rise_cyc = cyc;
        if (trigger_out === 1'b1) hi_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_trig = trigger_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, DW'($urandom_range(0, 63)), WW'($urandom_range(0, 15)),
                 16'($urandom_range(0, 5)));
    endtask

    initial begin
        longint T;
        int     h0, d0;

        rst = 1'b1; arm = 1'b0; disarm = 1'b0; edge_pulse = 1'b0;
        delay_cycles = '0; pulse_width = '0;
`ifdef TRIG_EDGE_COUNT_EN
        edge_count_target = '0;
`endif
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0);
        chk("reset_trigger_out", 64'(trigger_out), 64'd0);
        chk("reset_armed",       64'(armed),       64'd0);
        chk("reset_done",        64'(done),        64'd0);
        idle(2);

        // delay 5, width 3
        h0 = hi_cnt;
        step(0, 1, 0, 0, 6'd5, 4'd3, 16'd0);
        idle(1);
        T = cyc;
        step(0, 0, 0, 1, 6'd40, 4'd9, 16'd0);
        idle(12);
        chk("d5w3_rise_ofs", 64'(rise_cyc - T), 64'd6);
        chk("d5w3_high_len", 64'(hi_cnt - h0),  64'd3);
        chk("d5w3_done_ofs", 64'(done_cyc - T), 64'd9);

        // delay 0, width 0; arm and edge together only arms
        h0 = hi_cnt;
        step(0, 1, 0, 1, 6'd0, 4'd0, 16'd1);
        T = cyc;
        step(0, 0, 0, 1, 6'd7, 4'd7, 16'd0);
        idle(5);
        chk("d0w0_rise_ofs", 64'(rise_cyc - T), 64'd1);
        chk("d0w0_high_len", 64'(hi_cnt - h0),  64'd1);
        chk("d0w0_done_ofs", 64'(done_cyc - T), 64'd2);

        // disarm mid-delay, then a stray edge
        h0 = hi_cnt; d0 = done_cnt;
        step(0, 1, 0, 0, 6'd10, 4'd2, 16'd0);
        T = cyc;
        step(0, 0, 0, 1, 6'd1, 4'd1, 16'd0);
        idle(2);
        step(0, 1, 1, 1, 6'd1, 4'd1, 16'd0);
        chk("disarm_busy", 64'(busy), 64'd0);
        idle(1);
        step(0, 0, 0, 1, 6'd0, 4'd0, 16'd0);
        idle(20);
        chk("disarm_no_trig", 64'(hi_cnt - h0),   64'd0);
        chk("disarm_no_done", 64'(done_cnt - d0), 64'd0);

        // rst during pulse, then normal operation
        d0 = done_cnt;
        step(0, 1, 0, 0, 6'd1, 4'd5, 16'd0);
        step(0, 0, 0, 1, 6'd0, 4'd0, 16'd0);
        idle(2);
        step(1, 0, 0, 0, 6'd0, 4'd0, 16'd0);
        chk("rst_pulse_trig", 64'(trigger_out), 64'd0);
        chk("rst_pulse_busy", 64'(busy),        64'd0);
        idle(6);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        h0 = hi_cnt;
        step(0, 1, 0, 0, 6'd2, 4'd2, 16'd0);
        T = cyc;
        step(0, 0, 0, 1, 6'd0, 4'd0, 16'd0);
        idle(8);
        chk("post_rst_rise_ofs", 64'(rise_cyc - T), 64'd3);
        chk("post_rst_high_len", 64'(hi_cnt - h0),  64'd2);

        // edges at T, T+4, T+9 with target 3, delay 2
        h0 = hi_cnt;
        step(0, 1, 0, 0, 6'd2, 4'd1, 16'd3);
        T = cyc;
        step(0, 0, 0, 1, 6'd0, 4'd0, 16'd0);
        idle(3);
        step(0, 0, 0, 1, 6'd0, 4'd0, 16'd0);
        idle(4);
        step(0, 0, 0, 1, 6'd0, 4'd0, 16'd0);
        idle(8);
`ifdef TRIG_EDGE_COUNT_EN
        chk("edge_count_rise_ofs", 64'(rise_cyc - T), 64'd12);
`else
        chk("edge_count_rise_ofs", 64'(rise_cyc - T), 64'd3);
`endif
        chk("edge_count_high_len", 64'(hi_cnt - h0), 64'd1);

        // full-range delay and width
        h0 = hi_cnt;
        step(0, 1, 0, 0, 6'd63, 4'd15, 16'd0);
        T = cyc;
        step(0, 0, 0, 1, 6'd0, 4'd0, 16'd0);
        idle(85);
        chk("max_rise_ofs", 64'(rise_cyc - T), 64'd64);
        chk("max_high_len", 64'(hi_cnt - h0),  64'd15);
        chk("max_done_ofs", 64'(done_cyc - T), 64'd79);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 63)) : DW'($urandom_range(0, 8)),
                 WW'($urandom_range(0, 15)),
                 16'($urandom_range(0, 4)));
        end
        idle(90);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/trigger_delay_fsm.md
TRIGGER_DELAY_FSM -- requirements
Module: trigger_delay_fsm

Interface
REQ-001 The module SHALL provide parameter DELAY_W, default 32, the width of the delay count in clk cycles.
REQ-002 The module SHALL provide parameter WIDTH_W, default 16, the width of the output pulse-width count in clk cycles.
REQ-003 Port clk  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst  input  1  reset; it SHALL be synchronous and active-high.
REQ-005 Port edge_pulse  input  1  single-cycle trigger event, already synchronised and edge-qualified.
REQ-006 Port arm  input  1  one-cycle request to arm a single-shot trigger.
REQ-007 Port disarm  input  1  one-cycle request to abort; returns the module to idle.
REQ-008 Port delay_cycles  input  DELAY_W  delay from the qualifying edge to trigger_out rising.
REQ-009 Port pulse_width  input  WIDTH_W  trigger_out high time in cycles.
REQ-010 Port edge_count_target  input  16  number of edges to the firing edge; present only under TRIG_EDGE_COUNT_EN.
REQ-011 Port trigger_out  output  1  registered, delayed trigger pulse.
REQ-012 Port armed  output  1  high while in ARMED.
REQ-013 Port busy  output  1  high while in DELAY or PULSE.
REQ-014 Port done  output  1  one-cycle pulse on completion of the output pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, ARMED, DELAY and PULSE, all of them registered.
REQ-016 IDLE->ARMED SHALL occur on arm; delay_cycles, pulse_width and edge_count_target SHALL be latched in that cycle, and later input changes SHALL have no effect until the next arm.
REQ-017 ARMED->DELAY SHALL occur on the qualifying edge_pulse; the delay counter SHALL load the latched delay.
REQ-018 DELAY->PULSE SHALL occur when the delay counter reaches 0; trigger_out SHALL go high in the first PULSE cycle.
REQ-019 Latency: edge_pulse high in cycle T -> trigger_out high from cycle T+1+D, where D is the latched delay; D=0 -> T+1.
REQ-020 trigger_out SHALL stay high exactly max(pulse_width,1) cycles; pulse_width=0 is treated as 1.
REQ-021 PULSE->IDLE SHALL occur after the last high cycle; done SHALL be high in the first IDLE cycle, for one cycle only.
REQ-022 edge_pulse in IDLE, DELAY or PULSE SHALL be ignored, with no queuing.
REQ-023 arm outside IDLE SHALL be ignored.
REQ-024 disarm in any state SHALL force IDLE next cycle with trigger_out=0 and done=0; disarm wins over a simultaneous arm or edge_pulse.
REQ-025 arm and edge_pulse in the same IDLE cycle SHALL only arm; that edge does not count.
REQ-026 Counters SHALL be unsigned with no wrap; delay_cycles at all-ones SHALL give exactly 2^DELAY_W-1 cycles of delay.
REQ-027 armed, busy and trigger_out SHALL be decoded from registered state, so no combinational path exists from the inputs.

Reset
REQ-028 rst SHALL force IDLE and clear all counters and latched config; trigger_out, armed, busy and done SHALL all be 0 in the cycle after rst is sampled.
REQ-029 rst mid-DELAY or mid-PULSE SHALL abort immediately, with no done pulse.

Configuration
REQ-030 Macro TRIG_EDGE_COUNT_EN defined: ARMED SHALL count edge_pulse events and leave only on the Nth edge, where N=max(edge_count_target,1); the edge counter SHALL clear on arm, disarm and rst.
REQ-031 Macro TRIG_EDGE_COUNT_EN undefined: the edge_count_target port and the edge counter SHALL be absent, and the first edge in ARMED SHALL qualify.

Structure
REQ-032 Shared package trigger_delay_pkg SHALL hold the state enum typedef and the default DELAY_W and WIDTH_W constants.
REQ-033 One sub-module, tdu_down_counter (loadable, saturating at 0, zero flag), SHALL be instantiated twice: once for the delay and once for the pulse width.

Verification
REQ-034 arm, delay=5, width=3, edge at T -> trigger_out high T+6..T+8, done at T+9, armed low from T+1.
REQ-035 delay=0, width=0, edge at T -> trigger_out high at T+1 only, done at T+2.
REQ-036 disarm at T+3 during delay=10 -> IDLE at T+4, no trigger_out, no done; a second edge has no effect.
REQ-037 rst asserted during PULSE -> all outputs 0 next cycle; a subsequent arm/edge sequence operates normally.
REQ-038 TRIG_EDGE_COUNT_EN, target=3, delay=2, edges at T, T+4, T+9 -> trigger_out high at T+12; with the macro undefined, the same stimulus gives trigger_out high at T+3.
